geofence_tri_area: RTL and testbench

GEOFENCE_TRI_AREA -- requirements
Module: geofence_tri_area

---
 rtl/geofence_tri_area.sv | 172 +++++++++++++++++
 tb/tb_geofence_tri_area.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/geofence_tri_area.sv
// Geofence triangle-area stage: per record, side a = isqrt(edge_sq), Heron's
// product p = s(s-a)(s-ra)(s-rb), t = isqrt(p); six t values are accumulated
// and compared against the upstream hexagon area.
module geofence_tri_area (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [21:0] in_edge_sq,
  input  logic [10:0] in_ra,
  input  logic [10:0] in_rb,
  input  logic [21:0] hex_area,
  output logic        valid,
  output logic        is_inside
);

  typedef enum logic [2:0] {IDLE, SQE, MUL, SQA, ACC, CMP, DONE} state_t;

  state_t      state;
  logic [4:0]  cyc;
  logic [2:0]  rec_cnt;
  logic [26:0] acc;
  logic [21:0] edge_l;
  logic [21:0] hex_l;
  logic [10:0] ra_l;
  logic [10:0] rb_l;
  logic [10:0] side_a;
  logic [23:0] p1;
  logic [23:0] p2;
  // rad doubles as the Heron product register; it is shifted out by the root
  logic [47:0] rad;
  logic [24:0] rem;
  logic [23:0] root;

  logic [26:0] rem_sh;
  logic [26:0] trial;
  logic        fits;
  logic [24:0] rem_nx;
  logic [23:0] root_nx;
  logic [12:0] peri;
  logic [11:0] semi;
  logic [11:0] d_a;
  logic [11:0] d_ra;
  logic [11:0] d_rb;
  logic [47:0] prod_nx;

  // One restoring square-root step shared by SQE and SQA, plus Heron terms
  always_comb begin
    rem_sh  = {rem, rad[47:46]};
    trial   = {1'b0, root, 2'b01};
    fits    = (rem_sh >= trial);
    rem_nx  = fits ? 25'(rem_sh - trial) : rem_sh[24:0];
    root_nx = {root[22:0], fits};
    peri    = 13'(side_a) + 13'(ra_l) + 13'(rb_l);
    semi    = 12'(peri >> 1);
    d_a     = (semi > 12'(side_a)) ? semi - 12'(side_a) : '0;
    d_ra    = (semi > 12'(ra_l))   ? semi - 12'(ra_l)   : '0;
    d_rb    = (semi > 12'(rb_l))   ? semi - 12'(rb_l)   : '0;
    prod_nx = 48'(p1) * 48'(p2);
  end

  // Frame control FSM with registered handshake and result outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cyc       <= '0;
      rec_cnt   <= '0;
      acc       <= '0;
      edge_l    <= '0;
      hex_l     <= '0;
      ra_l      <= '0;
      rb_l      <= '0;
      side_a    <= '0;
      p1        <= '0;
      p2        <= '0;
      rad       <= '0;
      rem       <= '0;
      root      <= '0;
      in_ready  <= 1'b1;
      valid     <= 1'b0;
      is_inside <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            edge_l   <= in_edge_sq;
            ra_l     <= in_ra;
            rb_l     <= in_rb;
            if (rec_cnt == 3'd0) hex_l <= hex_area;
            in_ready <= 1'b0;
            cyc      <= '0;
            state    <= SQE;
          end
        end
        // First SQE cycle primes the root engine; 11 bit cycles follow
        SQE: begin
          if (cyc == 5'd0) begin
            rad  <= {edge_l, 26'd0};
            rem  <= '0;
            root <= '0;
            cyc  <= 5'd1;
          end else begin
            rad  <= {rad[45:0], 2'b00};
            rem  <= rem_nx;
            root <= root_nx;
            if (cyc == 5'd11) begin
              side_a <= root_nx[10:0];
              cyc    <= '0;
              state  <= MUL;
            end else begin
              cyc <= cyc + 5'd1;
            end
          end
        end
        MUL: begin
          case (cyc)
            5'd0: begin
              p1  <= 24'(semi) * 24'(d_a);
              cyc <= 5'd1;
            end
            5'd1: begin
              p2  <= 24'(d_ra) * 24'(d_rb);
              cyc <= 5'd2;
            end
            default: begin
              rad   <= prod_nx;
              rem   <= '0;
              root  <= '0;
              cyc   <= '0;
              state <= SQA;
            end
          endcase
        end
        SQA: begin
          rad  <= {rad[45:0], 2'b00};
          rem  <= rem_nx;
          root <= root_nx;
          if (cyc == 5'd23) begin
            cyc   <= '0;
            state <= ACC;
          end else begin
            cyc <= cyc + 5'd1;
          end
        end
        ACC: begin
          acc     <= acc + 27'(root);
          rec_cnt <= rec_cnt + 3'd1;
          if (rec_cnt == 3'd5) begin
            state <= CMP;
          end else begin
            in_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        CMP: begin
          is_inside <= (acc <= {5'd0, hex_l});
          valid     <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          valid    <= 1'b0;
          acc      <= '0;
          rec_cnt  <= '0;
          in_ready <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_geofence_tri_area.sv
// Bench for geofence_tri_area: table-driven single-record frames, fixed
// frames, reset mid-frame, and random frames against a Heron-formula model.
module tb_geofence_tri_area;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [21:0] in_edge_sq;
  logic [10:0] in_ra;
  logic [10:0] in_rb;
  logic [21:0] hex_area;
  logic        valid;
  logic        is_inside;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc   = 0;

  typedef struct {
    logic [21:0] e;
    logic [10:0] ra;
    logic [10:0] rb;
    longint      t;
  } rec_t;

  rec_t frame_recs[6];
  rec_t vecs[7];

  geofence_tri_area dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_edge_sq (in_edge_sq),
    .in_ra      (in_ra),
    .in_rb      (in_rb),
    .hex_area   (hex_area),
    .valid      (valid),
    .is_inside  (is_inside)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  function automatic longint isqrt(input longint n);
    longint r;
    r = longint'($floor($sqrt(real'(n))));
    while (r * r > n) r--;
    while ((r + 1) * (r + 1) <= n) r++;
    return r;
  endfunction

  function automatic longint heron_t(input longint e, input longint ra, input longint rb);
    longint a, s, da, dra, drb;
    a   = isqrt(e);
    s   = (a + ra + rb) / 2;
    da  = (s > a)  ? s - a  : 0;
    dra = (s > ra) ? s - ra : 0;
    drb = (s > rb) ? s - rb : 0;
    return isqrt(s * da * dra * drb);
  endfunction

  // Feed frame_recs with in_valid held high; check handshake timing and result
  task automatic run_frame(input logic [21:0] hex, input logic exp_in, input string nm);
    int unsigned acc_edge;
    bit ok;
    acc_edge = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid   = 1'b1;
      in_edge_sq = frame_recs[i].e;
      in_ra      = frame_recs[i].ra;
      in_rb      = frame_recs[i].rb;
      hex_area   = (i == 0) ? hex : 22'($urandom);
      ok = 0;
      for (int w = 0; w < 200; w++) begin
        if (in_ready) begin
          ok = 1;
          break;
        end
        @(negedge clk);
      end
      if (!ok) begin
        check({nm, " ready_timeout"}, 0, 1);
        in_valid = 1'b0;
        return;
      end
      if (i > 0) check({nm, " ready_gap"}, longint'(cyc - acc_edge), 40);
      acc_edge = cyc + 1;
      @(posedge clk);
      #1;
      check({nm, " ready_low_after_accept"}, longint'(in_ready), 0);
      in_edge_sq = 22'($urandom);
      in_ra      = 11'($urandom);
      in_rb      = 11'($urandom);
    end
    ok = 0;
    for (int w = 0; w < 200; w++) begin
      @(negedge clk);
      if (valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      check({nm, " valid_timeout"}, 0, 1);
      in_valid = 1'b0;
      return;
    end
    in_valid = 1'b0;
    check({nm, " valid_latency"}, longint'(cyc - acc_edge), 41);
    check({nm, " is_inside"}, longint'(is_inside), longint'(exp_in));
    @(negedge clk);
    check({nm, " valid_width"}, longint'(valid), 0);
    check({nm, " is_inside_held"}, longint'(is_inside), longint'(exp_in));
  endtask

  task automatic fill_same(input logic [21:0] e, input logic [10:0] ra, input logic [10:0] rb);
    for (int i = 0; i < 6; i++) begin
      frame_recs[i].e  = e;
      frame_recs[i].ra = ra;
      frame_recs[i].rb = rb;
    end
  endtask

  initial begin
    longint sum, hx;
    logic [21:0] e;
    logic [10:0] ra, rb;
    longint maxe;
    bit ok;

    vecs[0] = '{e: 22'd25,       ra: 11'd3,    rb: 11'd4,    t: 6};
    vecs[1] = '{e: 22'd100,      ra: 11'd1,    rb: 11'd1,    t: 0};
    vecs[2] = '{e: 22'd0,        ra: 11'd0,    rb: 11'd0,    t: 0};
    vecs[3] = '{e: 22'h3FFFFF,   ra: 11'd2047, rb: 11'd2047, t: 1812936};
    vecs[4] = '{e: 22'd169,      ra: 11'd5,    rb: 11'd12,   t: 30};
    vecs[5] = '{e: 22'd26,       ra: 11'd3,    rb: 11'd4,    t: 6};
    vecs[6] = '{e: 22'd24,       ra: 11'd3,    rb: 11'd4,    t: 3};

    reset = 1'b1; in_valid = 1'b0; in_edge_sq = '0; in_ra = '0; in_rb = '0; hex_area = '0;
    #1;
    check("reset in_ready", longint'(in_ready), 1);
    check("reset valid", longint'(valid), 0);
    check("reset is_inside", longint'(is_inside), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Single nonzero record followed by five zero records isolates one t
    for (int v = 0; v < 7; v++) begin
      fill_same('0, '0, '0);
      frame_recs[0] = vecs[v];
      run_frame(22'(vecs[v].t), 1'b1, $sformatf("vec%0d at_t", v));
      if (vecs[v].t > 0) run_frame(22'(vecs[v].t - 1), 1'b0, $sformatf("vec%0d below_t", v));
    end

    fill_same(22'd25, 11'd3, 11'd4);
    run_frame(22'd36, 1'b1, "basic hex36");
    run_frame(22'd35, 1'b0, "basic hex35");
    run_frame(22'd37, 1'b1, "basic hex37");

    fill_same(22'd100, 11'd1, 11'd1);
    run_frame(22'd0, 1'b1, "clamp hex0");

    // Reset during SQA of record 3, after a frame left is_inside high
    fill_same(22'd25, 11'd3, 11'd4);
    run_frame(22'd36, 1'b1, "pre_reset");
    @(negedge clk);
    in_valid = 1'b1; in_edge_sq = 22'd25; in_ra = 11'd3; in_rb = 11'd4; hex_area = 22'd0;
    for (int k = 0; k < 3; k++) begin
      ok = 0;
      for (int w = 0; w < 200; w++) begin
        if (in_ready) begin
          ok = 1;
          break;
        end
        @(negedge clk);
      end
      if (!ok) check("reset_seq ready_timeout", 0, 1);
      @(posedge clk);
      #1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (24) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midreset in_ready", longint'(in_ready), 1);
    check("midreset valid", longint'(valid), 0);
    check("midreset is_inside", longint'(is_inside), 0);
    @(negedge clk);
    reset = 1'b0;
    run_frame(22'd35, 1'b0, "post_reset hex35");
    run_frame(22'd36, 1'b1, "post_reset hex36");

    // Random frames against the Heron model
    for (int f = 0; f < 8; f++) begin
      sum = 0;
      for (int i = 0; i < 6; i++) begin
        ra = 11'($urandom_range(0, 2047));
        rb = 11'($urandom_range(0, 2047));
        maxe = (longint'(ra) + longint'(rb)) * (longint'(ra) + longint'(rb));
        if (maxe > 64'h3FFFFF) maxe = 64'h3FFFFF;
        e = 22'($urandom_range(0, int'(maxe)));
        if ($urandom_range(0, 7) == 0) begin
          e = '0; ra = '0; rb = '0;
        end
        frame_recs[i].e  = e;
        frame_recs[i].ra = ra;
        frame_recs[i].rb = rb;
        sum += heron_t(e, ra, rb);
      end
      if (sum <= 64'h3FFFFF) begin
        hx = sum + longint'($urandom_range(0, 2)) - 1;
        if (hx < 0) hx = 0;
        if (hx > 64'h3FFFFF) hx = 64'h3FFFFF;
      end else begin
        hx = longint'($urandom_range(0, 22'h3FFFFF));
      end
      run_frame(22'(hx), (sum <= hx), $sformatf("rand%0d", f));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
